// File: rtl/dlsc_axi_splitter_rd.sv
// Single-master AXI read splitter: decodes each read command to one of OUTPUTS
// slaves, answers unmapped reads locally with DECERR, and returns data in command order.
module dlsc_axi_splitter_rd #(
  parameter int unsigned ADDR    = 32,
  parameter int unsigned DATA    = 32,
  parameter int unsigned LEN     = 4,
  parameter int unsigned MOT     = 8,
  parameter int unsigned OUTPUTS = 2,
  parameter logic [OUTPUTS*ADDR-1:0] MASKS = {(OUTPUTS*ADDR){1'b1}},
  parameter logic [OUTPUTS*ADDR-1:0] BASES = {(OUTPUTS*ADDR){1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    in_ar_ready,
  input  logic                    in_ar_valid,
  input  logic [ADDR-1:0]         in_ar_addr,
  input  logic [LEN-1:0]          in_ar_len,
  input  logic                    in_r_ready,
  output logic                    in_r_valid,
  output logic                    in_r_last,
  output logic [DATA-1:0]         in_r_data,
  output logic [1:0]              in_r_resp,
  input  logic [OUTPUTS-1:0]      out_ar_ready,
  output logic [OUTPUTS-1:0]      out_ar_valid,
  output logic [OUTPUTS*ADDR-1:0] out_ar_addr,
  output logic [OUTPUTS*LEN-1:0]  out_ar_len,
  output logic [OUTPUTS-1:0]      out_r_ready,
  input  logic [OUTPUTS-1:0]      out_r_valid,
  input  logic [OUTPUTS-1:0]      out_r_last,
  input  logic [OUTPUTS*DATA-1:0] out_r_data,
  input  logic [OUTPUTS*2-1:0]    out_r_resp
);

  localparam int unsigned SELW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int unsigned PTRW = $clog2(MOT);
  localparam int unsigned CNTW = PTRW + 1;

  logic                dec_hit;
  logic [SELW-1:0]     dec_sel;
  logic [OUTPUTS-1:0]  dec_onehot;

  logic                fifo_err [MOT];
  logic [SELW-1:0]     fifo_sel [MOT];
  logic [LEN-1:0]      fifo_len [MOT];
  logic [PTRW-1:0]     wr_ptr;
  logic [PTRW-1:0]     rd_ptr;
  logic [CNTW-1:0]     count;
  logic [LEN-1:0]      beat;

  logic [ADDR-1:0]     ar_addr;
  logic [LEN-1:0]      ar_len;
  logic                busy;
  logic                ar_fire;
  logic                push;
  logic                pop;
  logic                empty;
  logic                head_err;
  logic [SELW-1:0]     head_sel;
  logic [LEN-1:0]      head_len;

  // Address decode; iterating downward lets the lowest matching index win
  always_comb begin
    dec_hit    = 1'b0;
    dec_sel    = '0;
    dec_onehot = '0;
    for (int j = int'(OUTPUTS) - 1; j >= 0; j--) begin
      if ((in_ar_addr & MASKS[j*ADDR +: ADDR]) == BASES[j*ADDR +: ADDR]) begin
        dec_hit    = 1'b1;
        dec_sel    = SELW'(j);
        dec_onehot = OUTPUTS'(1) << j;
      end
    end
  end

  assign busy        = |out_ar_valid;
  assign ar_fire     = |(out_ar_valid & out_ar_ready);
  assign in_ar_ready = !busy && (count < CNTW'(MOT));
  assign push        = in_ar_valid && in_ar_ready;
  assign empty       = (count == '0);
  assign pop         = in_r_valid && in_r_ready && in_r_last;

  assign head_err = fifo_err[rd_ptr];
  assign head_sel = fifo_sel[rd_ptr];
  assign head_len = fifo_len[rd_ptr];

  assign out_ar_addr = {OUTPUTS{ar_addr}};
  assign out_ar_len  = {OUTPUTS{ar_len}};

  // AR register stage: the one-hot valid vector doubles as the busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_ar_valid <= '0;
      ar_addr      <= '0;
      ar_len       <= '0;
    end else if (push && dec_hit) begin
      out_ar_valid <= dec_onehot;
      ar_addr      <= in_ar_addr;
      ar_len       <= in_ar_len;
    end else if (ar_fire) begin
      out_ar_valid <= '0;
    end
  end

  // Order FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MOT); i++) begin
        fifo_err[i] <= 1'b0;
        fifo_sel[i] <= '0;
        fifo_len[i] <= '0;
      end
    end else if (push) begin
      fifo_err[wr_ptr] <= !dec_hit;
      fifo_sel[wr_ptr] <= dec_sel;
      fifo_len[wr_ptr] <= in_ar_len;
    end
  end

  // Order FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      if (push && !pop) begin
        count <= count + CNTW'(1);
      end else if (pop && !push) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // DECERR beat counter, wraps to zero on the last beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
    end else if (!empty && head_err && in_r_ready) begin
      beat <= (beat == head_len) ? '0 : beat + LEN'(1);
    end
  end

  // R return path muxed by the registered FIFO head
  always_comb begin
    in_r_valid  = 1'b0;
    in_r_last   = 1'b0;
    in_r_data   = '0;
    in_r_resp   = '0;
    out_r_ready = '0;
    if (!empty) begin
      if (head_err) begin
        in_r_valid = 1'b1;
        in_r_last  = (beat == head_len);
        in_r_resp  = 2'b11;
      end else begin
        for (int j = 0; j < int'(OUTPUTS); j++) begin
          if (head_sel == SELW'(j)) begin
            in_r_valid     = out_r_valid[j];
            in_r_last      = out_r_last[j];
            in_r_data      = out_r_data[j*DATA +: DATA];
            in_r_resp      = out_r_resp[j*2 +: 2];
            out_r_ready[j] = in_r_ready;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dlsc_axi_splitter_rd.sv
// Bench for dlsc_axi_splitter_rd: random and directed reads against a two-slave
// model, with in-order beat scoreboard and per-slave AR expectation queues.
module tb_dlsc_axi_splitter_rd;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_ar_ready, in_ar_valid;
  logic [31:0] in_ar_addr;
  logic [3:0]  in_ar_len;
  logic        in_r_ready, in_r_valid, in_r_last;
  logic [31:0] in_r_data;
  logic [1:0]  in_r_resp;
  logic [1:0]  out_ar_ready, out_ar_valid;
  logic [63:0] out_ar_addr;
  logic [7:0]  out_ar_len;
  logic [1:0]  out_r_ready, out_r_valid, out_r_last;
  logic [63:0] out_r_data;
  logic [3:0]  out_r_resp;

  int checks = 0;
  int failures = 0;
  int rr_mode = 1;
  logic [1:0] slave_en = 2'b11;

  beat_t exp_r[$];
  cmd_t  exp_ar[2][$];
  cmd_t  pend[2][$];
  int    bidx[2];
  logic  acc[2];
  logic  in_rst = 1'b1;
  logic  prev_stall = 1'b0;

  dlsc_axi_splitter_rd #(
    .ADDR(32), .DATA(32), .LEN(4), .MOT(4), .OUTPUTS(2),
    .MASKS({32'hF000_0000, 32'hF000_0000}),
    .BASES({32'h1000_0000, 32'h0000_0000})
  ) dut (
    .clk(clk), .rst(rst),
    .in_ar_ready(in_ar_ready), .in_ar_valid(in_ar_valid),
    .in_ar_addr(in_ar_addr), .in_ar_len(in_ar_len),
    .in_r_ready(in_r_ready), .in_r_valid(in_r_valid), .in_r_last(in_r_last),
    .in_r_data(in_r_data), .in_r_resp(in_r_resp),
    .out_ar_ready(out_ar_ready), .out_ar_valid(out_ar_valid),
    .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len),
    .out_r_ready(out_r_ready), .out_r_valid(out_r_valid), .out_r_last(out_r_last),
    .out_r_data(out_r_data), .out_r_resp(out_r_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Slave read data is a fixed function of the command address and beat index
  function automatic logic [31:0] sdata(input logic [31:0] a, input int b);
    return a ^ (32'(b) << 20) ^ 32'h5A00_0000;
  endfunction

  // Reference decode: window j is [j*0x1000_0000, +0x1000_0000)
  function automatic int ref_decode(input logic [31:0] a);
    for (int j = 0; j < 2; j++) begin
      if (a[31:28] == 4'(j)) return j;
    end
    return -1;
  endfunction

  // Present one command; on acceptance record the expected AR and R beats
  task automatic issue(input logic [31:0] a, input logic [3:0] l, output int waits);
    int s;
    bit ok;
    beat_t e;
    waits = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    in_ar_valid = 1'b1;
    in_ar_addr  = a;
    in_ar_len   = l;
    while (!ok && waits <= 500) begin
      @(negedge clk);
      if (in_ar_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ar_accept_timeout actual=not_accepted required=accepted addr=0x%0h", a);
    end else begin
      s = ref_decode(a);
      if (s >= 0) exp_ar[s].push_back(cmd_t'{a, l});
      for (int b = 0; b <= int'(l); b++) begin
        e.data = (s >= 0) ? sdata(a, b) : 32'h0;
        e.resp = (s < 0) ? 2'b11 : ((s == 0) ? 2'b00 : 2'b01);
        e.last = (b == int'(l));
        exp_r.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_ar_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_r.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_r.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=%0d_beats_left required=0", name, exp_r.size());
    end
    @(posedge clk); #1;
  endtask

  // Master ready driver
  initial begin
    in_r_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: in_r_ready = ($urandom % 4) != 0;
        1: in_r_ready = 1'b1;
        2: in_r_ready = !in_r_ready;
        default: in_r_ready = 1'b0;
      endcase
    end
  end

  // Slave models plus AR monitor
  initial begin
    cmd_t c;
    out_ar_ready = '0;
    out_r_valid  = '0;
    out_r_last   = '0;
    out_r_data   = '0;
    out_r_resp   = '0;
    bidx[0] = 0; bidx[1] = 0;
    forever begin
      @(negedge clk);
      in_rst = !rst;
      for (int j = 0; j < 2; j++) begin
        acc[j] = 1'b0;
        if (!rst) begin
          pend[j].delete();
          exp_ar[j].delete();
          bidx[j] = 0;
        end else begin
          if (out_ar_valid[j] && out_ar_ready[j]) begin
            if (exp_ar[j].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL ar_unexpected slave=%0d actual=0x%0h required=none", j, out_ar_addr[j*32 +: 32]);
            end else begin
              c = exp_ar[j].pop_front();
              chk("ar_addr", 64'(out_ar_addr[j*32 +: 32]), 64'(c.addr));
              chk("ar_len", 64'(out_ar_len[j*4 +: 4]), 64'(c.len));
            end
            pend[j].push_back(cmd_t'{out_ar_addr[j*32 +: 32], out_ar_len[j*4 +: 4]});
          end
          if (out_r_valid[j] && out_r_ready[j]) begin
            acc[j] = 1'b1;
            if (out_r_last[j]) begin
              c = pend[j].pop_front();
              bidx[j] = 0;
            end else begin
              bidx[j]++;
            end
          end
        end
      end
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        out_ar_ready[j] = ($urandom % 3) != 0;
        if (in_rst) begin
          out_r_valid[j] = 1'b0;
        end else if (out_r_valid[j] && !acc[j]) begin
          out_r_valid[j] = 1'b1;
        end else if (pend[j].size() > 0 && slave_en[j] && ($urandom % 4) != 0) begin
          out_r_valid[j]          = 1'b1;
          out_r_data[j*32 +: 32]  = sdata(pend[j][0].addr, bidx[j]);
          out_r_last[j]           = (bidx[j] == int'(pend[j][0].len));
          out_r_resp[j*2 +: 2]    = (j == 0) ? 2'b00 : 2'b01;
        end else begin
          out_r_valid[j] = 1'b0;
        end
      end
    end
  end

  // Master R monitor: in-order scoreboard and valid-hold check
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("r_valid_hold", 64'(in_r_valid), 64'd1);
      if (in_r_valid && in_r_ready) begin
        if (exp_r.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r_unexpected actual=0x%0h required=none", in_r_data);
        end else begin
          e = exp_r.pop_front();
          chk("r_data", 64'(in_r_data), 64'(e.data));
          chk("r_resp", 64'(in_r_resp), 64'(e.resp));
          chk("r_last", 64'(in_r_last), 64'(e.last));
        end
      end
      prev_stall = in_r_valid && !in_r_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic prev_pop;
    logic [31:0] a;
    int n;
    rst = 1'b0;
    in_ar_valid = 1'b0;
    in_ar_addr = '0;
    in_ar_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_r_valid", 64'(in_r_valid), 64'd0);
    chk("rst_out_ar_valid", 64'(out_ar_valid), 64'd0);
    chk("rst_out_r_ready", 64'(out_r_ready), 64'd0);
    chk("rst_out_ar_addr", out_ar_addr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_in_ar_ready", 64'(in_ar_ready), 64'd1);

    // Mapped read to slave 1
    rr_mode = 1;
    issue(32'h1000_0040, 4'd3, w);
    #1;
    chk("ar_valid_n1", 64'(out_ar_valid), 64'b10);
    chk("ar_addr_n1", out_ar_addr, {32'h1000_0040, 32'h1000_0040});
    chk("ar_len_n1", 64'(out_ar_len), 64'h33);
    drain("map1");
    chk("map1_empty", 64'(in_r_valid), 64'd0);

    // Unmapped read answered with DECERR
    issue(32'h2000_0000, 4'd2, w);
    #1;
    chk("decerr_valid_n1", 64'(in_r_valid), 64'd1);
    chk("decerr_resp_n1", 64'(in_r_resp), 64'd3);
    chk("decerr_data_n1", 64'(in_r_data), 64'd0);
    chk("decerr_no_ar", 64'(out_ar_valid), 64'd0);
    drain("decerr");

    // Ordering: slave 0 ready first but must wait behind slave 1
    slave_en = 2'b01;
    issue(32'h1000_0100, 4'd0, w);
    issue(32'h0000_0200, 4'd0, w);
    repeat (6) @(negedge clk);
    chk("order_hold_s0", 64'(out_r_ready[0]), 64'd0);
    chk("order_no_valid", 64'(in_r_valid), 64'd0);
    slave_en = 2'b11;
    drain("order");

    // Outstanding limit
    slave_en = 2'b00;
    issue(32'h1000_0010, 4'd1, w);
    issue(32'h0000_0020, 4'd1, w);
    issue(32'h1000_0030, 4'd0, w);
    issue(32'h0000_0040, 4'd2, w);
    n = 0;
    while (out_ar_valid != 2'b00 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("mot_full_ready", 64'(in_ar_ready), 64'd0);
    slave_en = 2'b11;
    prev_pop = 1'b0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (in_ar_ready) break;
      prev_pop = in_r_valid && in_r_ready && in_r_last;
      n++;
    end
    chk("mot_release_ready", 64'(in_ar_ready), 64'd1);
    chk("mot_release_after_pop", 64'(prev_pop), 64'd1);
    issue(32'h2000_0000, 4'd0, w);
    chk("mot_fifth_waits", 64'(w), 64'd0);
    drain("mot");

    // DECERR burst under toggling backpressure
    rr_mode = 2;
    issue(32'h3000_0000, 4'd3, w);
    drain("bp");

    // Reset with three outstanding commands
    rr_mode = 3;
    slave_en = 2'b00;
    issue(32'h4000_0000, 4'd3, w);
    issue(32'h1000_0000, 4'd2, w);
    issue(32'h0000_0000, 4'd1, w);
    #1;
    chk("pre_rst_valid", 64'(in_r_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_r_valid", 64'(in_r_valid), 64'd0);
    chk("mid_rst_out_ar_valid", 64'(out_ar_valid), 64'd0);
    chk("mid_rst_out_r_ready", 64'(out_r_ready), 64'd0);
    chk("mid_rst_out_ar_addr", out_ar_addr, 64'd0);
    exp_r.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ar_ready), 64'd1);
    issue(32'h1000_0080, 4'd1, w);
    chk("post_rst_waits", 64'(w), 64'd0);
    rr_mode = 0;
    slave_en = 2'b11;
    drain("post_rst");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 4)
        0: a = {4'h0, 28'($urandom)};
        1: a = {4'h1, 28'($urandom)};
        2: a = {4'h2, 28'($urandom)};
        default: a = {4'hF, 28'($urandom)};
      endcase
      issue(a & 32'hFFFF_FFFC, 4'($urandom), w);
      repeat ($urandom % 3) @(posedge clk);
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
